// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter
// Datapath stage of the stopwatch. A prescaler turns clk into a one-second tick.
// Four BCD digits (MM:SS) count on that tick, cascade with carries and wrap at 99:59.
// Optional lap-hold feature: define STOPWATCH_LAP_HOLD_EN to add the lap/lap_active
// ports and a 16-bit hold register that can freeze the display.
module stopwatch_time_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_en,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
  output logic       lap_active,
`endif
  output logic [3:0] disp_min_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones,
  output logic       sec_pulse,
  output logic       rollover
);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    secOnes_q, secOnes_d;
  logic [3:0]    secTens_q, secTens_d;
  logic [3:0]    minOnes_q, minOnes_d;
  logic [3:0]    minTens_q, minTens_d;
  logic          secPulse_q, secPulse_d;
  logic          rollover_q, rollover_d;
  logic          tick;

  // A digit above its legal maximum (only possible after an upset) is treated
  // as the maximum, so it wraps and carries on the next tick.
  function automatic logic [3:0] clampDigit(input logic [3:0] d, input logic [3:0] maxVal);
    return (d > maxVal) ? maxVal : d;
  endfunction

  assign tick = count_en && (presc_q == PRESC_LAST);

  // Next-state for prescaler, live digits and the pulse outputs; clear overrides everything.
  always_comb begin
    logic [3:0] sOnes, sTens, mOnes, mTens;
    logic       carrySec, carryTen, carryMin;
    presc_d    = presc_q;
    secOnes_d  = secOnes_q;
    secTens_d  = secTens_q;
    minOnes_d  = minOnes_q;
    minTens_d  = minTens_q;
    secPulse_d = 1'b0;
    rollover_d = 1'b0;
    sOnes      = clampDigit(secOnes_q, 4'd9);
    sTens      = clampDigit(secTens_q, 4'd5);
    mOnes      = clampDigit(minOnes_q, 4'd9);
    mTens      = clampDigit(minTens_q, 4'd9);
    carrySec   = (sOnes == 4'd9);
    carryTen   = carrySec && (sTens == 4'd5);
    carryMin   = carryTen && (mOnes == 4'd9);
    if (clear) begin
      presc_d   = '0;
      secOnes_d = 4'd0;
      secTens_d = 4'd0;
      minOnes_d = 4'd0;
      minTens_d = 4'd0;
    end else if (tick) begin
      presc_d    = '0;
      secPulse_d = 1'b1;
      secOnes_d  = carrySec ? 4'd0 : sOnes + 4'd1;
      if (carrySec) begin
        secTens_d = carryTen ? 4'd0 : sTens + 4'd1;
      end
      if (carryTen) begin
        minOnes_d = carryMin ? 4'd0 : mOnes + 4'd1;
      end
      if (carryMin) begin
        minTens_d  = (mTens == 4'd9) ? 4'd0 : mTens + 4'd1;
        rollover_d = (mTens == 4'd9);
      end
    end else if (count_en) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // State register for prescaler, live digits and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      secOnes_q  <= 4'd0;
      secTens_q  <= 4'd0;
      minOnes_q  <= 4'd0;
      minTens_q  <= 4'd0;
      secPulse_q <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      secOnes_q  <= secOnes_d;
      secTens_q  <= secTens_d;
      minOnes_q  <= minOnes_d;
      minTens_q  <= minTens_d;
      secPulse_q <= secPulse_d;
      rollover_q <= rollover_d;
    end
  end

  assign sec_pulse = secPulse_q;
  assign rollover  = rollover_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        holdActive_q, holdActive_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] disp_q, disp_d;

  // Lap toggle: capture the pre-tick live value on entry, release on the next lap.
  // The display register is fed from next-state values so it stays aligned with the digits.
  always_comb begin
    holdActive_d = holdActive_q;
    hold_d       = hold_q;
    if (clear) begin
      holdActive_d = 1'b0;
      hold_d       = 16'h0000;
    end else if (lap) begin
      if (!holdActive_q) begin
        holdActive_d = 1'b1;
        hold_d       = {minTens_q, minOnes_q, secTens_q, secOnes_q};
      end else begin
        holdActive_d = 1'b0;
      end
    end
    disp_d = holdActive_d ? hold_d : {minTens_d, minOnes_d, secTens_d, secOnes_d};
  end

  // Hold register, hold flag and registered display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdActive_q <= 1'b0;
      hold_q       <= 16'h0000;
      disp_q       <= 16'h0000;
    end else begin
      holdActive_q <= holdActive_d;
      hold_q       <= hold_d;
      disp_q       <= disp_d;
    end
  end

  assign lap_active    = holdActive_q;
  assign disp_min_tens = disp_q[15:12];
  assign disp_min_ones = disp_q[11:8];
  assign disp_sec_tens = disp_q[7:4];
  assign disp_sec_ones = disp_q[3:0];
`else
  assign disp_min_tens = minTens_q;
  assign disp_min_ones = minOnes_q;
  assign disp_sec_tens = secTens_q;
  assign disp_sec_ones = secOnes_q;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed testbench for stopwatch_time_counter: one instance with TICK_DIV=4,
// one with TICK_DIV=1. Lap-hold checks run when STOPWATCH_LAP_HOLD_EN is defined.
module tb_stopwatch_time_counter;

  logic clk;
  logic rst_n;
  logic en4, clr4, en1, clr1;
  logic [3:0] mt4, mo4, st4, so4, mt1, mo1, st1, so1;
  logic pulse4, roll4, pulse1, roll1;
  logic [15:0] disp4, disp1;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap4, lap1, lapActive4, lapActive1;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int pulseCount4;
  int enabledIdx4;
  int lastPulseIdx4;
  int firstPulseIdx4;
  int pulseLows1;

  assign disp4 = {mt4, mo4, st4, so4};
  assign disp1 = {mt1, mo1, st1, so1};

  stopwatch_time_counter #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .count_en(en4), .clear(clr4),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap4), .lap_active(lapActive4),
`endif
    .disp_min_tens(mt4), .disp_min_ones(mo4), .disp_sec_tens(st4), .disp_sec_ones(so4),
    .sec_pulse(pulse4), .rollover(roll4)
  );

  stopwatch_time_counter #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .count_en(en1), .clear(clr1),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap1), .lap_active(lapActive1),
`endif
    .disp_min_tens(mt1), .disp_min_ones(mo1), .disp_sec_tens(st1), .disp_sec_ones(so1),
    .sec_pulse(pulse1), .rollover(roll1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tickClk();
    @(posedge clk);
    #1;
  endtask

  task automatic resetTally();
    pulseCount4    = 0;
    enabledIdx4    = 0;
    lastPulseIdx4  = 0;
    firstPulseIdx4 = 0;
  endtask

  task automatic applyStimulus(input logic en, input int n);
    en4 = en;
    for (int c = 0; c < n; c++) begin
      tickClk();
      if (en) enabledIdx4++;
      if (pulse4) begin
        if (pulseCount4 == 0) firstPulseIdx4 = enabledIdx4;
        else checkOutput("pulse_spacing", enabledIdx4 - lastPulseIdx4, 4);
        lastPulseIdx4 = enabledIdx4;
        pulseCount4++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en4 = 1'b0; clr4 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    lap4 = 1'b0; lap1 = 1'b0;
`endif
    #3;
    checkOutput("reset_disp4", disp4, 16'h0000);
    checkOutput("reset_pulse4", pulse4, 0);
    checkOutput("reset_roll4", roll4, 0);
    checkOutput("reset_presc4", dut4.presc_q, 0);
    checkOutput("reset_disp1", disp1, 16'h0000);
`ifdef STOPWATCH_LAP_HOLD_EN
    checkOutput("reset_lap_active", lapActive1, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] 40 enabled cycles at TICK_DIV=4");
    resetTally();
    applyStimulus(1'b1, 40);
    en4 = 1'b0;
    checkOutput("run40_pulses", pulseCount4, 10);
    checkOutput("run40_first", firstPulseIdx4, 4);
    checkOutput("run40_disp", disp4, 16'h0010);

    $display("[TB] pause keeps partial second");
    clr4 = 1'b1; tickClk(); clr4 = 1'b0;
    checkOutput("clear_disp", disp4, 16'h0000);
    resetTally();
    applyStimulus(1'b1, 2);
    checkOutput("pause_presc_before", dut4.presc_q, 2);
    applyStimulus(1'b0, 10);
    checkOutput("pause_presc_held", dut4.presc_q, 2);
    checkOutput("pause_disp_held", disp4, 16'h0000);
    applyStimulus(1'b1, 2);
    en4 = 1'b0;
    checkOutput("pause_pulses", pulseCount4, 1);
    checkOutput("pause_first", firstPulseIdx4, 4);
    checkOutput("pause_disp", disp4, 16'h0001);

    $display("[TB] clear coinciding with tick");
    clr4 = 1'b1; tickClk(); clr4 = 1'b0;
    resetTally();
    applyStimulus(1'b1, 39);
    checkOutput("pre_clear_disp", disp4, 16'h0009);
    checkOutput("pre_clear_presc", dut4.presc_q, 3);
    clr4 = 1'b1;
    tickClk();
    clr4 = 1'b0;
    en4 = 1'b0;
    checkOutput("clr_tick_disp", disp4, 16'h0000);
    checkOutput("clr_tick_presc", dut4.presc_q, 0);
    checkOutput("clr_tick_pulse", pulse4, 0);
    checkOutput("clr_tick_roll", roll4, 0);

    $display("[TB] asynchronous reset mid-count");
    resetTally();
    applyStimulus(1'b1, 3018);
    checkOutput("pre_reset_disp", disp4, 16'h1234);
    checkOutput("pre_reset_presc", dut4.presc_q, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_disp", disp4, 16'h0000);
    checkOutput("async_reset_presc", dut4.presc_q, 0);
    checkOutput("async_reset_pulse", pulse4, 0);
    tickClk();
    rst_n = 1'b1;
    resetTally();
    applyStimulus(1'b1, 3);
    checkOutput("post_reset_no_pulse", pulseCount4, 0);
    applyStimulus(1'b1, 1);
    en4 = 1'b0;
    checkOutput("post_reset_disp", disp4, 16'h0001);

    $display("[TB] TICK_DIV=1 wrap at 99:59");
    clr1 = 1'b1; tickClk(); clr1 = 1'b0;
    en1 = 1'b1;
    pulseLows1 = 0;
    for (int c = 0; c < 5998; c++) begin
      tickClk();
      if (!pulse1) pulseLows1++;
    end
    checkOutput("div1_pulse_continuous", pulseLows1, 0);
    checkOutput("div1_presc_zero", dut1.presc_q, 0);
    checkOutput("div1_disp_9958", disp1, 16'h9958);
    tickClk();
    checkOutput("div1_disp_9959", disp1, 16'h9959);
    checkOutput("div1_roll_early", roll1, 0);
    tickClk();
    checkOutput("div1_disp_wrap", disp1, 16'h0000);
    checkOutput("div1_roll", roll1, 1);
    checkOutput("div1_pulse_wrap", pulse1, 1);
    en1 = 1'b0;
    tickClk();
    checkOutput("div1_roll_after", roll1, 0);
    checkOutput("div1_pulse_idle", pulse1, 0);

`ifdef STOPWATCH_LAP_HOLD_EN
    $display("[TB] lap hold at TICK_DIV=1");
    clr1 = 1'b1; tickClk(); clr1 = 1'b0;
    en1 = 1'b1;
    repeat (5) tickClk();
    checkOutput("lap_pre_disp", disp1, 16'h0005);
    lap1 = 1'b1; tickClk(); lap1 = 1'b0;
    checkOutput("lap_active_set", lapActive1, 1);
    checkOutput("lap_hold_disp", disp1, 16'h0005);
    repeat (2) tickClk();
    checkOutput("lap_hold_still", disp1, 16'h0005);
    checkOutput("lap_live_dut", {dut1.minTens_q, dut1.minOnes_q, dut1.secTens_q, dut1.secOnes_q}, 16'h0008);
    checkOutput("lap_pulse_live", pulse1, 1);
    lap1 = 1'b1; tickClk(); lap1 = 1'b0;
    checkOutput("lap_release_disp", disp1, 16'h0009);
    checkOutput("lap_active_clr", lapActive1, 0);
    lap1 = 1'b1; tickClk(); lap1 = 1'b0;
    checkOutput("lap_recapture", disp1, 16'h0009);
    clr1 = 1'b1; lap1 = 1'b1; tickClk(); clr1 = 1'b0; lap1 = 1'b0;
    en1 = 1'b0;
    checkOutput("lap_clear_active", lapActive1, 0);
    checkOutput("lap_clear_disp", disp1, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_counter.md
# stopwatch_time_counter

Downstream datapath stage of the stopwatch: consumes `count_en` and `clear` from the control FSM and produces the elapsed time as four BCD digits (MM:SS). An internal prescaler divides `clk` into a one-second tick. The prescaler's fractional count is preserved across pause. Digits cascade with carries and wrap at 99:59. Outputs drive the display multiplexer directly.

## Interface
- `TICK_DIV`, default 100000000: `clk` cycles per counted second. Legal values are 1 and up.
- `PW`, default `$clog2(TICK_DIV)` (minimum 1): prescaler width. Derived; not to be overridden.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `count_en` input 1: level signal; when high, time advances.
- `clear` input 1: synchronous clear, one or more cycles.
- `lap` input 1: single-cycle lap toggle pulse. Present only with `LAP_HOLD_EN`.
- `disp_min_tens` output 4: displayed minutes tens digit, range 0–9.
- `disp_min_ones` output 4: displayed minutes ones digit, range 0–9.
- `disp_sec_tens` output 4: displayed seconds tens digit, range 0–5.
- `disp_sec_ones` output 4: displayed seconds ones digit, range 0–9.
- `sec_pulse` output 1: one-cycle pulse each time the live count advances.
- `rollover` output 1: one-cycle pulse when the live count wraps from 99:59 to 00:00.
- `lap_active` output 1: high while the display is frozen. Present only with `LAP_HOLD_EN`.

## Operation
- **Prescaler.** `presc` is PW bits wide.
  - `tick` = `count_en` && (`presc` == TICK_DIV-1). `tick` is combinational and internal.
  - Count_en high, no tick: `presc` increments by 1.
  - Tick: `presc` goes to 0.
  - Count_en low: `presc` holds its value, so a pause does not lose the partial second.
- **Live digit cascade.** On the edge where `tick` is high, the live digits update:
  - `sec_ones` goes 9 to 0 and carries. Otherwise it increments.
  - `sec_tens` goes 5 to 0 and carries. Otherwise it increments.
  - `min_ones` goes 9 to 0 and carries.
  - `min_tens` goes 9 to 0. This case is the 99:59 to 00:00 wrap.
- **Clear.** `clear` has priority over `tick` and `count_en`. It zeroes `presc` and all live digits. No `sec_pulse` or `rollover` is produced in a clear cycle.
- **Illegal digit values.** These are unreachable. If one occurs (SEU), the next tick treats any digit greater than its maximum as its maximum, so the digit wraps and carries.
- **Display.** `disp_*` equals the live digits unless a lap hold is in effect (see Configuration).

## Timing
- **Reset** (`rst_n` low), asynchronous. Outputs and state take these values:
  - `presc`=0.
  - All live digits and `disp_*`=0.
  - `sec_pulse`=0, `rollover`=0, `lap_active`=0, hold register=0.
- **Digit latency.** Digits change on the same edge that `presc` returns to 0. The first second completes TICK_DIV enabled cycles after a clear or reset.
- **Pulse outputs.** `sec_pulse` and `rollover` are registered. Each goes high for exactly the one cycle following the tick edge, aligned with the new digit values.
- **Partial second across pause.** If `count_en` drops with `presc`=k, then on re-enable exactly TICK_DIV-k enabled cycles remain before the next tick.
- **TICK_DIV=1.** `presc` stays 0. Every enabled cycle is a tick, and `sec_pulse` stays high continuously while enabled.
- **Clear and tick together.** When `clear` and `tick` coincide, clear wins: digits go to 00:00 and there is no pulse.
- **Reset mid-second.** Any accumulated prescaler count is discarded. There is no residual pulse.
- All outputs are glitch-free registers. There is no combinational path from an input to an output.

## Configuration
- **Macro `STOPWATCH_LAP_HOLD_EN`.**
- **Defined:** the `lap` and `lap_active` ports exist, together with a 16-bit hold register.
  - `lap` while not held: the hold register captures the live digits on that edge. `lap_active` becomes 1 the next cycle.
  - While held: `disp_*` shows the hold register. The live count keeps running, and `sec_pulse` and `rollover` still track the live count.
  - `lap` while held: the hold is released. `disp_*` returns to live digits next cycle.
  - `clear` releases the hold and zeroes the hold register.
  - If `clear` and `lap` arrive together, clear wins.
  - `lap` coinciding with `tick`: the hold register captures the pre-tick value.
- **Undefined:** the ports and hold register are absent, and `disp_*` is always the live digits.

## Test plan
- Reset, then TICK_DIV=4, `count_en`=1 for 40 cycles. Expect digits 00:10, `sec_pulse` asserted 10 times at a 4-cycle spacing, first pulse at cycle 4.
- TICK_DIV=4, enable 2 cycles, disable 10 cycles, enable 2 cycles. Expect exactly one `sec_pulse`, on the 4th enabled cycle, and digits 00:01.
- TICK_DIV=1, force count to 99:58, enable 2 cycles. Expect 99:59 then 00:00, with `rollover` high only in the cycle after the second edge.
- TICK_DIV=4 at 00:09 with `presc`=3. Assert `clear` together with `count_en`. Expect 00:00, `presc`=0, `sec_pulse`=0, `rollover`=0.
- `rst_n` low mid-count at 12:34 with `presc`=2. Expect all outputs at 0 immediately (asynchronously). After release and 4 enabled cycles, expect 00:01.
- With the macro defined and TICK_DIV=1: `lap` at 00:05, run 3 cycles, then `lap`. Expect `disp_*` to hold 00:05 with `lap_active`=1 while live reaches 00:08, then `disp_*` shows the live 00:09 one cycle after release.
